// File: rtl/img_coder_pkg.sv
// Shared constants for the bitplane coding path: subband region tables,
// widths and scheduler FSM encoding.
package img_coder_pkg;

    localparam int unsigned PLANE_W = 4;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned POS_W   = 6;
    localparam int unsigned SB_W    = 3;

    localparam logic [SB_W-1:0] SB_LL2 = 3'd0;
    localparam logic [SB_W-1:0] SB_HL2 = 3'd1;
    localparam logic [SB_W-1:0] SB_LH2 = 3'd2;
    localparam logic [SB_W-1:0] SB_HH2 = 3'd3;
    localparam logic [SB_W-1:0] SB_HL1 = 3'd4;
    localparam logic [SB_W-1:0] SB_LH1 = 3'd5;
    localparam logic [SB_W-1:0] SB_HH1 = 3'd6;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_ISSUE      = 2'd1;
    localparam logic [1:0] ST_WAIT_CODER = 2'd2;
    localparam logic [1:0] ST_DONE       = 2'd3;

    function automatic logic [POS_W-1:0] sb_row0(input logic [SB_W-1:0] sb);
        case (sb)
            SB_LH2, SB_HH2: return 6'd16;
            SB_LH1, SB_HH1: return 6'd32;
            default:        return 6'd0;
        endcase
    endfunction

    function automatic logic [POS_W-1:0] sb_col0(input logic [SB_W-1:0] sb);
        case (sb)
            SB_HL2, SB_HH2: return 6'd16;
            SB_HL1, SB_HH1: return 6'd32;
            default:        return 6'd0;
        endcase
    endfunction

    function automatic logic [POS_W-1:0] sb_row_last(input logic [SB_W-1:0] sb);
        case (sb)
            SB_LL2, SB_HL2: return 6'd15;
            SB_LH2, SB_HH2,
            SB_HL1:         return 6'd31;
            default:        return 6'd63;
        endcase
    endfunction

    function automatic logic [POS_W-1:0] sb_col_last(input logic [SB_W-1:0] sb);
        case (sb)
            SB_LL2, SB_LH2: return 6'd15;
            SB_HL2, SB_HH2,
            SB_LH1:         return 6'd31;
            default:        return 6'd63;
        endcase
    endfunction

endpackage

// File: rtl/subband_scan_counter.sv
// Row/col/subband position register walking the 7 subbands in coding order,
// raster scan inside each region; wraps to LL2 origin after HH1.
module subband_scan_counter
    import img_coder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [SB_W-1:0]  sb,
    output logic [POS_W-1:0] row,
    output logic [POS_W-1:0] col,
    output logic             region_first,
    output logic             image_end
);

    logic             row_end;
    logic             col_end;
    logic             region_end;
    logic [SB_W-1:0]  sb_nx;
    logic [POS_W-1:0] row_nx;
    logic [POS_W-1:0] col_nx;

    assign row_end      = (row == sb_row_last(sb));
    assign col_end      = (col == sb_col_last(sb));
    assign region_end   = row_end && col_end;
    assign image_end    = region_end && (sb == SB_HH1);
    assign region_first = (row == sb_row0(sb)) && (col == sb_col0(sb));

    always_comb begin
        sb_nx  = sb;
        row_nx = row;
        col_nx = col + 1'b1;
        if (col_end) begin
            col_nx = sb_col0(sb);
            row_nx = row + 1'b1;
            if (row_end) begin
                sb_nx  = (sb == SB_HH1) ? SB_LL2 : sb + 1'b1;
                row_nx = sb_row0(sb_nx);
                col_nx = sb_col0(sb_nx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb  <= SB_LL2;
            row <= '0;
            col <= '0;
        end else if (clear) begin
            sb  <= SB_LL2;
            row <= '0;
            col <= '0;
        end else if (advance) begin
            sb  <= sb_nx;
            row <= row_nx;
            col <= col_nx;
        end
    end

endmodule

// File: rtl/bitplane_scheduler.sv
// Walks bitplanes top_plane..MIN_PLANE, issuing one centre address per
// coefficient to ram_reader, paced by coder_ready and rd_ack.
module bitplane_scheduler #(
    parameter int unsigned MIN_PLANE = 0,
    parameter int unsigned ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wavelet_end,
    input  logic [3:0]        top_plane,
    input  logic              stop_req,
    input  logic              coder_ready,
    input  logic              rd_ack,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [2:0]        subband,
    output logic [3:0]        plane,
    output logic              sb_first,
    output logic              plane_first,
    output logic              busy,
    output logic              code_done
);
    import img_coder_pkg::*;

    localparam logic [PLANE_W-1:0] MIN_P = PLANE_W'(MIN_PLANE);

    logic [1:0]       state;
    logic             stop_lat;
    logic [POS_W-1:0] row;
    logic [POS_W-1:0] col;
    logic             region_first;
    logic             image_end;
    logic             start;
    logic             transfer;
    logic             last_coef;

    assign start     = (state == ST_IDLE) && wavelet_end;
    assign transfer  = (state == ST_ISSUE) && rd_ack;
    assign last_coef = image_end && ((plane == MIN_P) || stop_lat);

    subband_scan_counter u_scan (
        .clk          (clk),
        .rst          (rst),
        .clear        (start),
        .advance      (transfer),
        .sb           (subband),
        .row          (row),
        .col          (col),
        .region_first (region_first),
        .image_end    (image_end)
    );

    assign rd_req      = (state == ST_ISSUE);
    assign rd_addr     = ADDR_W'({row, col});
    assign sb_first    = rd_req && region_first;
    assign plane_first = rd_req && region_first && (subband == SB_LL2);
    assign busy        = (state == ST_ISSUE) || (state == ST_WAIT_CODER);
    assign code_done   = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            plane    <= '0;
            stop_lat <= 1'b0;
        end else begin
            // stop request only matters while a run is in flight
            stop_lat <= (state == ST_IDLE) ? 1'b0 : (stop_lat || stop_req);
            case (state)
                ST_IDLE: begin
                    if (wavelet_end) begin
                        plane <= top_plane;
                        state <= (top_plane < MIN_P) ? ST_DONE : ST_WAIT_CODER;
                    end
                end
                ST_WAIT_CODER: begin
                    if (coder_ready)
                        state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (rd_ack) begin
                        if (last_coef) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_WAIT_CODER;
                            if (image_end)
                                plane <= plane - 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
